// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game key command decoder:
// direction encoding, HID usage codes, fire FSM states and a width helper.
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    READY        = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } fire_state_t;

  localparam int NUM_PLAYERS = 2;

  // USB HID usage codes
  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_P1_UP    = 8'h1A;  // W
  localparam logic [7:0] KEY_P1_DOWN  = 8'h16;  // S
  localparam logic [7:0] KEY_P1_LEFT  = 8'h04;  // A
  localparam logic [7:0] KEY_P1_RIGHT = 8'h07;  // D
  localparam logic [7:0] KEY_P1_FIRE  = 8'h2C;  // space
  localparam logic [7:0] KEY_P2_UP    = 8'h52;  // arrow up
  localparam logic [7:0] KEY_P2_DOWN  = 8'h51;  // arrow down
  localparam logic [7:0] KEY_P2_LEFT  = 8'h50;  // arrow left
  localparam logic [7:0] KEY_P2_RIGHT = 8'h4F;  // arrow right
  localparam logic [7:0] KEY_P2_FIRE  = 8'h28;  // enter
  localparam logic [7:0] KEY_RESTART  = 8'h15;  // R

  // Frame ticks the restart key must be held before restart fires
  localparam int RESTART_HOLD_TICKS = 60;

  // Counter width able to hold 0..n, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fire_ctrl.sv
// Per-player fire controller: READY -> COOLDOWN -> WAIT_RELEASE.
// A shot is only taken from READY on a frame tick; holding fire never
// auto-repeats, the key must be seen released on a tick first.
import tank_pkg::*;

module fire_ctrl #(
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_tick,
  input  logic fire_key,
  output logic fire
);

  localparam int CD_W = cnt_w(COOLDOWN_FRAMES);

  fire_state_t     state, state_nx;
  logic [CD_W-1:0] cnt, cnt_nx;
  logic            fire_nx;

  // State, cooldown counter and registered fire pulse
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= READY;
      cnt   <= '0;
      fire  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      fire  <= fire_nx;
    end
  end

  // Next state; everything only moves on a frame tick
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire_nx  = 1'b0;
    if (frame_tick) begin
      unique case (state)
        READY: begin
          if (fire_key) begin
            fire_nx  = 1'b1;
            cnt_nx   = CD_W'(COOLDOWN_FRAMES);
            state_nx = COOLDOWN;
          end
        end
        COOLDOWN: begin
          // The tick that brings the count to zero ends the cooldown;
          // the count saturates at zero rather than wrapping.
          if (cnt <= CD_W'(1)) begin
            cnt_nx   = '0;
            state_nx = fire_key ? WAIT_RELEASE : READY;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!fire_key) state_nx = READY;
        end
        default: begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_command_decoder.sv
// Keyboard command decoder for the two-player tank game.
// Debounces the HID keycode, turns the stable key into per-frame movement
// commands and rate-limited fire pulses for each player.
// Optional: define KEYCMD_RESTART_EN to enable the hold-R-to-restart pulse.
import tank_pkg::*;

module key_command_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       p1_move_valid,
  output logic       p2_move_valid,
  output dir_t       p1_dir,
  output dir_t       p2_dir,
  output logic       p1_fire,
  output logic       p2_fire,
  output logic       restart
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);

  logic [7:0]             key_q, stable_key;
  logic [DB_W-1:0]        db_cnt;
  logic [NUM_PLAYERS-1:0] dec_is_dir, fire_held, fire_p, mv_q;
  dir_t                   dec_dir [NUM_PLAYERS];
  dir_t                   dir_q   [NUM_PLAYERS];

  // Debounce: the stable key follows the sample only after it has matched
  // for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_q      <= KEY_NONE;
      db_cnt     <= '0;
      stable_key <= KEY_NONE;
    end else begin
      key_q <= keycode;
      if (keycode != key_q) db_cnt <= '0;
      else if (db_cnt != DB_W'(DEBOUNCE_CYCLES)) db_cnt <= db_cnt + 1'b1;
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) stable_key <= key_q;
    end
  end

  // Key map: direction and fire decode per player
  always_comb begin
    dec_is_dir = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) dec_dir[p] = UP;
    unique case (stable_key)
      KEY_P1_UP:    begin dec_is_dir[0] = 1'b1; dec_dir[0] = UP;    end
      KEY_P1_DOWN:  begin dec_is_dir[0] = 1'b1; dec_dir[0] = DOWN;  end
      KEY_P1_LEFT:  begin dec_is_dir[0] = 1'b1; dec_dir[0] = LEFT;  end
      KEY_P1_RIGHT: begin dec_is_dir[0] = 1'b1; dec_dir[0] = RIGHT; end
      KEY_P2_UP:    begin dec_is_dir[1] = 1'b1; dec_dir[1] = UP;    end
      KEY_P2_DOWN:  begin dec_is_dir[1] = 1'b1; dec_dir[1] = DOWN;  end
      KEY_P2_LEFT:  begin dec_is_dir[1] = 1'b1; dec_dir[1] = LEFT;  end
      KEY_P2_RIGHT: begin dec_is_dir[1] = 1'b1; dec_dir[1] = RIGHT; end
      default:      ;
    endcase
    fire_held[0] = (stable_key == KEY_P1_FIRE);
    fire_held[1] = (stable_key == KEY_P2_FIRE);
  end

  // Movement: one-cycle valid after a tick; direction holds between commands
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mv_q <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) dir_q[p] <= (p == 0) ? UP : DOWN;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        mv_q[p] <= frame_tick && dec_is_dir[p];
        if (frame_tick && dec_is_dir[p]) dir_q[p] <= dec_dir[p];
      end
    end
  end

  // One independent fire controller per player, all stepped by the same tick
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_fire
    fire_ctrl #(
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_fire (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_tick(frame_tick),
      .fire_key  (fire_held[p]),
      .fire      (fire_p[p])
    );
  end

`ifdef KEYCMD_RESTART_EN
  localparam int HOLD_W = cnt_w(RESTART_HOLD_TICKS);

  logic [HOLD_W-1:0] hold_cnt;
  logic              restart_q;

  // Restart: count ticks while R is stable; fire once when the count
  // completes, then park at the full count until R is released.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hold_cnt  <= '0;
      restart_q <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (stable_key != KEY_RESTART) begin
        hold_cnt <= '0;
      end else if (frame_tick) begin
        if (hold_cnt == HOLD_W'(RESTART_HOLD_TICKS - 1)) begin
          restart_q <= 1'b1;
          hold_cnt  <= HOLD_W'(RESTART_HOLD_TICKS);
        end else if (hold_cnt < HOLD_W'(RESTART_HOLD_TICKS - 1)) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  assign restart = restart_q;
`else
  assign restart = 1'b0;
`endif

  assign p1_move_valid = mv_q[0];
  assign p2_move_valid = mv_q[1];
  assign p1_dir        = dir_q[0];
  assign p2_dir        = dir_q[1];
  assign p1_fire       = fire_p[0];
  assign p2_fire       = fire_p[1];

endmodule
